// File: rtl/sd_card_pkg.sv
// Shared constants for the SD clock generator: register map, FSM encodings
// and the width of the divider / burst fields.
package sd_card_pkg;

    localparam int FIELD_W = 16;

    typedef logic [FIELD_W-1:0] field_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_BURST  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

endpackage

// File: rtl/sd_card_clk_div.sv
// Half-period counter for the SD clock. Counts 0..N and reloads N only at a
// wrap or while disabled, so a DIV change never shortens the phase in progress.
module sd_card_clk_div
    import sd_card_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable,
    input  field_t n,
    output logic   wrap
);

    field_t count;
    field_t n_cur;

    // Terminal-count flag; the caller qualifies it with its own state.
    assign wrap = (count == n_cur);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            n_cur <= '0;
        end else if (!enable || wrap) begin
            count <= '0;
            n_cur <= n;
        end else begin
            count <= count + field_t'(1);
        end
    end

endmodule

// File: rtl/sd_card_sd_clk_gen.sv
// Avalon-MM programmable SD card clock generator with free-run and counted
// burst modes; sd_clk only ever stops after a complete high phase.
module sd_card_sd_clk_gen
    import sd_card_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd249
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        rise_stb,
    output logic        fall_stb
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       run;
    field_t     div;
    field_t     remaining;
    logic       wrap;
    logic       enable;
    logic       busy;
    logic       stop;
    logic       wr_en;
    logic       do_toggle;
    logic       do_rise;
    logic       do_fall;
    logic       unused_wdata;

    assign unused_wdata = ^writedata[31:FIELD_W];

    assign wr_en = chipselect && !write_n;
    assign busy  = (state != ST_IDLE);
    assign stop  = !run && (remaining == '0);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (run || remaining != '0) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (stop) next_state = (!sd_clk || wrap) ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
                if (wrap) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A stop during a low phase suppresses the pending rise to avoid a runt.
    assign do_toggle = busy && wrap && !(state == ST_ACTIVE && stop && !sd_clk);
    assign do_rise   = do_toggle && !sd_clk;
    assign do_fall   = do_toggle && sd_clk;
    assign enable    = busy && (next_state != ST_IDLE);

    sd_card_clk_div u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .n       (div),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sd_clk   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            state    <= next_state;
            rise_stb <= do_rise;
            fall_stb <= do_fall;
            if (do_toggle) sd_clk <= !sd_clk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            div       <= DIV_RESET;
            remaining <= '0;
        end else begin
            if (wr_en && address == ADDR_CTRL) run <= writedata[0];
            if (wr_en && address == ADDR_DIV)  div <= writedata[FIELD_W-1:0];
            if (wr_en && address == ADDR_BURST && !busy && !run &&
                writedata[FIELD_W-1:0] != '0) begin
                remaining <= writedata[FIELD_W-1:0];
            end else if (do_fall && remaining != '0) begin
                remaining <= remaining - field_t'(1);
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {31'd0, run};
            ADDR_DIV:    readdata = {16'd0, div};
            ADDR_BURST:  readdata = {16'd0, remaining};
            ADDR_STATUS: readdata = {remaining, 14'd0, sd_clk, busy};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sd_card_sd_clk_gen.sv
// Self-checking bench for sd_card_sd_clk_gen: pulse times are predicted from
// the divider and burst arithmetic and compared against observed strobes.
module tb_sd_card_sd_clk_gen;
    import sd_card_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        sd_clk;
    logic        rise_stb;
    logic        fall_stb;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rise_q[$];
    int fall_q[$];

    int w, r0, r1, r2, d, high, f1, f2;
    logic [31:0] s;

    sd_card_sd_clk_gen #(.DIV_RESET(16'd249)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Strobes are logged with the index of the edge that produced them.
    always @(negedge clk) begin
        if (rise_stb === 1'b1) rise_q.push_back(cyc);
        if (fall_stb === 1'b1) fall_q.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] data, output int wcyc);
        address    = a;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        wcyc       = cyc;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] data);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        data       = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_rise(output int rcyc);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rise_stb === 1'b1) begin
                rcyc = cyc;
                return;
            end
        end
        checkOutput("rise_timeout", 1, 0);
        rcyc = -1;
    endtask

    task automatic wait_idle(output int dcyc);
        logic [31:0] st;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            read_reg(ADDR_STATUS, st);
            if (st[0] === 1'b0) begin
                dcyc = cyc;
                return;
            end
        end
        checkOutput("idle_timeout", 1, 0);
        dcyc = -1;
    endtask

    function automatic int fall_after(input int t, input int nth);
        int seen = 0;
        foreach (fall_q[k]) begin
            if (fall_q[k] > t) begin
                seen++;
                if (seen == nth) return fall_q[k];
            end
        end
        return -1;
    endfunction

    // Counted burst from IDLE: edge k of sd_clk lands (k+1)(n+1) cycles after
    // the cycle in which the burst is first seen, which is one after the write.
    task automatic run_burst(input int n, input int c);
        int wb, db, mism;
        @(negedge clk);
        applyStimulus(ADDR_DIV, n, wb);
        rise_q.delete();
        fall_q.delete();
        applyStimulus(ADDR_BURST, c, wb);
        @(negedge clk);
        wait_idle(db);
        repeat (2) @(negedge clk);
        checkOutput("burst_rises", rise_q.size(), c);
        checkOutput("burst_falls", fall_q.size(), c);
        mism = 0;
        foreach (rise_q[k]) if (rise_q[k] != wb + 1 + (2 * k + 1) * (n + 1)) mism++;
        foreach (fall_q[k]) if (fall_q[k] != wb + 1 + (2 * k + 2) * (n + 1)) mism++;
        checkOutput("burst_timing", mism, 0);
        checkOutput("burst_busy_drop", db, wb + 1 + 2 * c * (n + 1) + 1);
        checkOutput("burst_sdclk_end", int'(sd_clk), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        read_reg(ADDR_DIV, s);
        checkOutput("reset_div", int'(s), 249);
        read_reg(ADDR_STATUS, s);
        checkOutput("reset_status", int'(s), 0);
        read_reg(ADDR_CTRL, s);
        checkOutput("reset_ctrl", int'(s), 0);
        high = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sd_clk !== 1'b0) high++;
        end
        checkOutput("reset_idle_sdclk", high, 0);
        checkOutput("reset_idle_pulses", rise_q.size() + fall_q.size(), 0);

        run_burst(0, 74);

        // Free run at N=3, then stop one cycle into a high phase.
        @(negedge clk);
        applyStimulus(ADDR_DIV, 3, w);
        rise_q.delete();
        fall_q.delete();
        applyStimulus(ADDR_CTRL, 1, w);
        wait_rise(r0);
        checkOutput("free_first_rise", r0, w + 5);
        wait_rise(r1);
        checkOutput("free_period", r1 - r0, 8);
        applyStimulus(ADDR_CTRL, 0, w);
        wait_idle(d);
        checkOutput("free_stop_busy_drop", d, r1 + 4);
        repeat (20) @(negedge clk);
        checkOutput("free_duty", fall_after(r0, 1) - r0, 4);
        checkOutput("free_last_high_phase", fall_after(r1, 1) - r1, 4);
        checkOutput("free_rise_count", rise_q.size(), 2);
        checkOutput("free_sdclk_end", int'(sd_clk), 0);

        // DIV 3 -> 1 written one cycle into a high phase.
        @(negedge clk);
        applyStimulus(ADDR_DIV, 3, w);
        rise_q.delete();
        fall_q.delete();
        applyStimulus(ADDR_CTRL, 1, w);
        wait_rise(r0);
        applyStimulus(ADDR_DIV, 1, w);
        wait_rise(r2);
        applyStimulus(ADDR_CTRL, 0, w);
        wait_idle(d);
        f1 = fall_after(r0, 1);
        f2 = fall_after(r0, 2);
        checkOutput("divchg_long_high", f1 - r0, 4);
        checkOutput("divchg_short_low", r2 - f1, 2);
        checkOutput("divchg_short_high", f2 - r2, 2);
        checkOutput("divchg_busy_drop", d, r2 + 2);

        // Second BURST while busy is ignored; BURST=0 from IDLE does nothing.
        @(negedge clk);
        applyStimulus(ADDR_DIV, 0, w);
        rise_q.delete();
        fall_q.delete();
        applyStimulus(ADDR_BURST, 10, w);
        repeat (3) @(negedge clk);
        applyStimulus(ADDR_BURST, 5, w);
        wait_idle(d);
        repeat (2) @(negedge clk);
        checkOutput("ignored_rises", rise_q.size(), 10);
        checkOutput("ignored_falls", fall_q.size(), 10);
        rise_q.delete();
        fall_q.delete();
        @(negedge clk);
        applyStimulus(ADDR_BURST, 0, w);
        high = 0;
        repeat (50) begin
            @(negedge clk);
            read_reg(ADDR_STATUS, s);
            if (s[0] !== 1'b0) high++;
        end
        checkOutput("zero_burst_busy", high, 0);
        checkOutput("zero_burst_pulses", rise_q.size() + fall_q.size(), 0);

        // Asynchronous reset in the high phase of the third pulse.
        @(negedge clk);
        applyStimulus(ADDR_DIV, 2, w);
        applyStimulus(ADDR_BURST, 20, w);
        wait_rise(r0);
        wait_rise(r0);
        wait_rise(r0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_sdclk_drop", int'(sd_clk), 0);
        read_reg(ADDR_STATUS, s);
        checkOutput("rst_status", int'(s), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rise_q.delete();
        fall_q.delete();
        repeat (100) @(negedge clk);
        checkOutput("rst_no_pulses", rise_q.size() + fall_q.size(), 0);
        read_reg(ADDR_STATUS, s);
        checkOutput("rst_status_after", int'(s), 0);
        read_reg(ADDR_DIV, s);
        checkOutput("rst_div_after", int'(s), 249);

        for (int i = 0; i < 6; i++) begin
            run_burst(int'($urandom_range(0, 5)), int'($urandom_range(1, 12)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
